// File: rtl/rx_packet_assembler.sv
// Receive packet assembler: frames classified bytes into little-endian 32-bit words
// queued in a show-ahead FIFO. Define DLLP_LEN_CHECK_EN to enforce 6-byte DLLP payloads.
module rx_packet_assembler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic [5:0]  type_in,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_dllp,
  output logic        out_nullify,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  output logic        overflow
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, TLP, DLLP} state_t;

  typedef struct packed {
    logic        nullify;
    logic        dllp;
    logic        eop;
    logic        sop;
    logic [3:0]  keep;
    logic [31:0] data;
  } entry_t;

  state_t state, state_nx;

  logic [31:0] asm_data, asm_data_nx;
  logic [2:0]  byte_cnt, byte_cnt_nx;
  logic        sop_pending, sop_pending_nx;
  logic        err_nx;
  logic        push;
  entry_t      push_entry;
  logic        close, close_null;

  logic is_data, is_ts, is_te, is_de, is_ds, is_edb;
  logic match_end, bad_end;

  assign is_data = (type_in == 6'b100000);
  assign is_ts   = (type_in == 6'b010000);
  assign is_te   = (type_in == 6'b001000);
  assign is_de   = (type_in == 6'b000100);
  assign is_ds   = (type_in == 6'b000010);
  assign is_edb  = (type_in == 6'b000001);

  assign match_end = ((state == TLP) && is_te) || ((state == DLLP) && is_de);
  assign bad_end   = ((state == TLP) && is_de) || ((state == DLLP) && is_te);

  logic len_bad;
`ifdef DLLP_LEN_CHECK_EN
  logic [2:0] dllp_cnt, dllp_cnt_nx;

  always_comb begin
    dllp_cnt_nx = dllp_cnt;
    if (is_ts || is_ds)
      dllp_cnt_nx = '0;
    else if ((state == DLLP) && is_data && (dllp_cnt != 3'd7))
      dllp_cnt_nx = dllp_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) dllp_cnt <= '0;
    else     dllp_cnt <= dllp_cnt_nx;
  end

  assign len_bad = (dllp_cnt != 3'd6);
`else
  assign len_bad = 1'b0;
`endif

  function automatic logic [3:0] keep_of(input logic [2:0] cnt);
    case (cnt)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (is_ts)      state_nx = TLP;
        else if (is_ds) state_nx = DLLP;
      end
      TLP, DLLP: begin
        if (is_ts)                         state_nx = TLP;
        else if (is_ds)                    state_nx = DLLP;
        else if (is_te || is_de || is_edb) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Any close pushes the held bytes first; a start symbol then re-opens the register.
  always_comb begin
    push           = 1'b0;
    push_entry     = '0;
    asm_data_nx    = asm_data;
    byte_cnt_nx    = byte_cnt;
    sop_pending_nx = sop_pending;
    err_nx         = 1'b0;
    close          = 1'b0;
    close_null     = 1'b0;

    if (state == IDLE) begin
      if ((type_in != '0) && !is_ts && !is_ds) err_nx = 1'b1;
    end else if (is_data) begin
      if (byte_cnt == 3'd4) begin
        push       = 1'b1;
        push_entry = '{nullify: 1'b0, dllp: (state == DLLP), eop: 1'b0,
                       sop: sop_pending, keep: 4'b1111, data: asm_data};
        sop_pending_nx = 1'b0;
        asm_data_nx    = {24'h0, data_in};
        byte_cnt_nx    = 3'd1;
      end else begin
        case (byte_cnt[1:0])
          2'd0:    asm_data_nx[7:0]   = data_in;
          2'd1:    asm_data_nx[15:8]  = data_in;
          2'd2:    asm_data_nx[23:16] = data_in;
          default: asm_data_nx[31:24] = data_in;
        endcase
        byte_cnt_nx = byte_cnt + 3'd1;
      end
    end else if (match_end) begin
      close      = 1'b1;
      close_null = (state == DLLP) && len_bad;
      err_nx     = (byte_cnt == 3'd0) || close_null;
    end else if (is_edb) begin
      close      = 1'b1;
      close_null = 1'b1;
    end else if (bad_end || is_ts || is_ds) begin
      close      = 1'b1;
      close_null = 1'b1;
      err_nx     = 1'b1;
    end

    if (close) begin
      push       = (byte_cnt != 3'd0);
      push_entry = '{nullify: close_null, dllp: (state == DLLP), eop: 1'b1,
                     sop: sop_pending, keep: keep_of(byte_cnt), data: asm_data};
      asm_data_nx    = '0;
      byte_cnt_nx    = '0;
      sop_pending_nx = 1'b0;
    end

    if (is_ts || is_ds) begin
      asm_data_nx    = '0;
      byte_cnt_nx    = '0;
      sop_pending_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_data    <= '0;
      byte_cnt    <= '0;
      sop_pending <= 1'b0;
      err         <= 1'b0;
    end else begin
      asm_data    <= asm_data_nx;
      byte_cnt    <= byte_cnt_nx;
      sop_pending <= sop_pending_nx;
      err         <= err_nx;
    end
  end

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push   = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && full && !pop) overflow <= 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_data    = head.data;
  assign out_keep    = head.keep;
  assign out_sop     = head.sop;
  assign out_eop     = head.eop;
  assign out_dllp    = head.dllp;
  assign out_nullify = head.nullify;

endmodule
